// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the vending controller and the change dispenser:
// FSM encodings, coin denominations, refill selector codes and prices.
package change_dispenser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    GAP,
    DONE
  } disp_state_e;

  // Upstream controller encoding lives here so both blocks agree on it
  typedef enum logic [1:0] {
    V_IDLE,
    V_COLLECT,
    V_VEND,
    V_CHANGE
  } vend_state_e;

  localparam logic [4:0] COIN_5  = 5'd5;
  localparam logic [4:0] COIN_10 = 5'd10;
  localparam logic [4:0] COIN_20 = 5'd20;

  localparam logic [1:0] SEL_5    = 2'd0;
  localparam logic [1:0] SEL_10   = 2'd1;
  localparam logic [1:0] SEL_20   = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  localparam logic [6:0] PRICE_A = 7'd25;
  localparam logic [6:0] PRICE_B = 7'd35;
  localparam logic [6:0] PRICE_C = 7'd50;

  function automatic logic [4:0] denom_value(input logic [1:0] sel);
    case (sel)
      SEL_5:   denom_value = COIN_5;
      SEL_10:  denom_value = COIN_10;
      SEL_20:  denom_value = COIN_20;
      default: denom_value = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Controller <-> change dispenser bundle. CHANGE_STATS_EN adds the
// payout statistics outputs.
interface change_dispenser_if #(parameter int INV_W = 6);
  logic [6:0]       change_amount;
  logic             change_ready;
  logic             refill;
  logic [1:0]       refill_sel;
  logic [INV_W-1:0] refill_qty;
  logic             coin_eject;
  logic [4:0]       coin_value;
  logic             busy;
  logic             done;
  logic [6:0]       shortfall;
  logic             overrun;
  logic [INV_W-1:0] inv_20, inv_10, inv_5;
  logic             empty_20, empty_10, empty_5;
`ifdef CHANGE_STATS_EN
  logic [15:0]      total_paid;
  logic [7:0]       short_events;

  modport master (
    output change_amount, change_ready, refill, refill_sel, refill_qty,
    input  coin_eject, coin_value, busy, done, shortfall, overrun,
    input  inv_20, inv_10, inv_5, empty_20, empty_10, empty_5,
    input  total_paid, short_events
  );
  modport slave (
    input  change_amount, change_ready, refill, refill_sel, refill_qty,
    output coin_eject, coin_value, busy, done, shortfall, overrun,
    output inv_20, inv_10, inv_5, empty_20, empty_10, empty_5,
    output total_paid, short_events
  );
`else
  modport master (
    output change_amount, change_ready, refill, refill_sel, refill_qty,
    input  coin_eject, coin_value, busy, done, shortfall, overrun,
    input  inv_20, inv_10, inv_5, empty_20, empty_10, empty_5
  );
  modport slave (
    input  change_amount, change_ready, refill, refill_sel, refill_qty,
    output coin_eject, coin_value, busy, done, shortfall, overrun,
    output inv_20, inv_10, inv_5, empty_20, empty_10, empty_5
  );
`endif
endinterface

// File: rtl/change_dispenser_coin_inventory.sv
// One denomination's coin count: saturating refill, decrement-if-nonzero,
// empty flag.
module coin_inventory #(
  parameter int INV_W = 6,
  parameter int INIT  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refill_i,
  input  logic [INV_W-1:0] refill_qty_i,
  input  logic             dec_i,
  output logic [INV_W-1:0] count_o,
  output logic             empty_o
);

  logic [INV_W-1:0] count_q, count_d;
  logic [INV_W:0]   sum;

  always_comb begin
    count_d = count_q;
    sum     = {1'b0, count_q} + {1'b0, refill_qty_i};
    if (dec_i && count_q != '0)
      count_d = count_q - 1'b1;
    else if (refill_i)
      count_d = sum[INV_W] ? '1 : sum[INV_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= INV_W'(INIT);
    else       count_q <= count_d;
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays an amount greedily (20/10/5) one coin at a time
// through the hopper ejector. CHANGE_STATS_EN adds total_paid/short_events.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int EJECT_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int INV_W        = 6,
  parameter int INIT_20      = 8,
  parameter int INIT_10      = 8,
  parameter int INIT_5       = 8
) (
  input  logic               clk,
  input  logic               reset,
  change_dispenser_if.slave  bus
);

  localparam int TMR_MAX = (EJECT_CYCLES > GAP_CYCLES) ? EJECT_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] EJECT_LOAD = TMR_W'(EJECT_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? TMR_W'(GAP_CYCLES - 1) : '0;

  disp_state_e      state_q;
  logic [6:0]       remaining_q;
  logic [TMR_W-1:0] timer_q;
  logic             coin_eject_q, busy_q, done_q, overrun_q;
  logic [4:0]       coin_value_q;
  logic [6:0]       shortfall_q;

  // index 0 = 5, 1 = 10, 2 = 20 (matches refill_sel encoding)
  logic [2:0][INV_W-1:0] inv;
  logic [2:0]            empty, dec, refill_en;

  logic       sel_found;
  logic [1:0] sel_idx;
  logic [4:0] sel_val;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = SEL_5;
    if (remaining_q >= 7'(COIN_20) && !empty[SEL_20]) begin
      sel_found = 1'b1;
      sel_idx   = SEL_20;
    end else if (remaining_q >= 7'(COIN_10) && !empty[SEL_10]) begin
      sel_found = 1'b1;
      sel_idx   = SEL_10;
    end else if (remaining_q >= 7'(COIN_5) && !empty[SEL_5]) begin
      sel_found = 1'b1;
      sel_idx   = SEL_5;
    end
    sel_val = denom_value(sel_idx);
  end

  for (genvar g = 0; g < 3; g++) begin : g_inv
    localparam int INIT_G = (g == 2) ? INIT_20 : (g == 1) ? INIT_10 : INIT_5;

    // A start request in the same cycle wins over a refill
    assign refill_en[g] = (state_q == IDLE) && !bus.change_ready && bus.refill &&
                          (bus.refill_sel == 2'(g));
    assign dec[g]       = (state_q == SELECT) && sel_found && (sel_idx == 2'(g));

    coin_inventory #(.INV_W(INV_W), .INIT(INIT_G)) u_inv (
      .clk          (clk),
      .reset        (reset),
      .refill_i     (refill_en[g]),
      .refill_qty_i (bus.refill_qty),
      .dec_i        (dec[g]),
      .count_o      (inv[g]),
      .empty_o      (empty[g])
    );
  end

`ifdef CHANGE_STATS_EN
  logic [15:0] total_paid_q;
  logic [7:0]  short_events_q;
  logic [16:0] paid_sum;

  assign paid_sum = {1'b0, total_paid_q} + 17'(sel_val);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      timer_q      <= '0;
      coin_eject_q <= 1'b0;
      coin_value_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      shortfall_q  <= '0;
      overrun_q    <= 1'b0;
`ifdef CHANGE_STATS_EN
      total_paid_q   <= '0;
      short_events_q <= '0;
`endif
    end else begin
      overrun_q <= bus.change_ready && (state_q != IDLE);
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.change_ready) begin
            remaining_q <= bus.change_amount;
            shortfall_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= SELECT;
          end
        end
        SELECT: begin
          if (sel_found) begin
            coin_eject_q <= 1'b1;
            coin_value_q <= sel_val;
            remaining_q  <= remaining_q - 7'(sel_val);
            timer_q      <= EJECT_LOAD;
            state_q      <= EJECT;
`ifdef CHANGE_STATS_EN
            total_paid_q <= paid_sum[16] ? 16'hFFFF : paid_sum[15:0];
`endif
          end else begin
            // Zero residue, odd residue and exhausted stock all end here
            shortfall_q <= remaining_q;
            done_q      <= 1'b1;
            state_q     <= DONE;
`ifdef CHANGE_STATS_EN
            if (remaining_q != '0 && short_events_q != 8'hFF)
              short_events_q <= short_events_q + 8'd1;
`endif
          end
        end
        EJECT: begin
          if (timer_q == '0) begin
            coin_eject_q <= 1'b0;
            coin_value_q <= '0;
            if (GAP_CYCLES == 0) begin
              state_q <= SELECT;
            end else begin
              timer_q <= GAP_LOAD;
              state_q <= GAP;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        GAP: begin
          if (timer_q == '0) state_q <= SELECT;
          else               timer_q <= timer_q - 1'b1;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.coin_eject = coin_eject_q;
  assign bus.coin_value = coin_value_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.shortfall  = shortfall_q;
  assign bus.overrun    = overrun_q;
  assign bus.inv_5      = inv[SEL_5];
  assign bus.inv_10     = inv[SEL_10];
  assign bus.inv_20     = inv[SEL_20];
  assign bus.empty_5    = empty[SEL_5];
  assign bus.empty_10   = empty[SEL_10];
  assign bus.empty_20   = empty[SEL_20];
`ifdef CHANGE_STATS_EN
  assign bus.total_paid   = total_paid_q;
  assign bus.short_events = short_events_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus random
// payouts/refills against a greedy-payout reference model.
module tb_change_dispenser;

  localparam int EJ   = 4;
  localparam int GP   = 2;
  localparam int IW   = 6;
  localparam int INIT = 8;
  localparam int PER  = 1 + EJ + GP;
  localparam int MAXI = (1 << IW) - 1;
  localparam int DV[3] = '{5, 10, 20};

  logic clk = 1'b0;
  logic reset = 1'b1;

  change_dispenser_if #(.INV_W(IW)) dif ();

  change_dispenser #(
    .EJECT_CYCLES(EJ), .GAP_CYCLES(GP), .INV_W(IW),
    .INIT_20(INIT), .INIT_10(INIT), .INIT_5(INIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int m_inv[3];
  int m_short;
`ifdef CHANGE_STATS_EN
  int m_paid, m_sev;
`endif

  function automatic int inv_of(input int k);
    case (k)
      0:       return int'(dif.inv_5);
      1:       return int'(dif.inv_10);
      default: return int'(dif.inv_20);
    endcase
  endfunction

  function automatic int empty_of(input int k);
    case (k)
      0:       return int'(dif.empty_5);
      1:       return int'(dif.empty_10);
      default: return int'(dif.empty_20);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_inv   = '{INIT, INIT, INIT};
    m_short = 0;
`ifdef CHANGE_STATS_EN
    m_paid = 0;
    m_sev  = 0;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dif.change_ready = 1'b0;
    dif.refill       = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // Drives one request and checks the payout cycle by cycle.
  task automatic run_payout(input int amt, input int ovr_c, input bit refill_mid,
                            input bit refill_with_start);
    int exp_q[$];
    int obs_q[$];
    int rem, cd, rise_c, exp_cd;
    bit found, prev_e;
    rem = amt;
    do begin
      found = 1'b0;
      for (int k = 2; k >= 0; k--)
        if (!found && rem >= DV[k] && m_inv[k] > 0) begin
          found = 1'b1;
          exp_q.push_back(DV[k]);
          rem -= DV[k];
          m_inv[k]--;
        end
    end while (found);
    m_short = rem;
`ifdef CHANGE_STATS_EN
    m_paid = (m_paid + amt - rem > 65535) ? 65535 : m_paid + amt - rem;
    if (rem != 0 && m_sev < 255) m_sev++;
`endif

    dif.change_amount = 7'(amt);
    dif.change_ready  = 1'b1;
    if (refill_with_start) begin
      dif.refill     = 1'b1;
      dif.refill_sel = 2'($urandom_range(0, 2));
      dif.refill_qty = IW'($urandom_range(1, MAXI));
    end
    cd = -1;
    rise_c = 0;
    prev_e = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      tick();
      n_cmp++;
      if (dif.busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy_high: amt %0d cycle +%0d busy=%0b expected 1", amt, c, dif.busy);
      end
      n_cmp++;
      if (dif.overrun !== (ovr_c > 0 && c == ovr_c + 1)) begin
        n_err++;
        $display("FAIL overrun: amt %0d cycle +%0d overrun=%0b expected %0b", amt, c,
                 dif.overrun, (ovr_c > 0 && c == ovr_c + 1));
      end
      if (dif.coin_eject && !prev_e) begin
        n_cmp++;
        if (c != 2 + PER * obs_q.size()) begin
          n_err++;
          $display("FAIL rise_time: amt %0d coin %0d rose at +%0d expected +%0d", amt,
                   obs_q.size(), c, 2 + PER * obs_q.size());
        end
        obs_q.push_back(int'(dif.coin_value));
        rise_c = c;
      end
      if (!dif.coin_eject && prev_e) begin
        n_cmp++;
        if (c - rise_c != EJ) begin
          n_err++;
          $display("FAIL eject_width: amt %0d width %0d expected %0d", amt, c - rise_c, EJ);
        end
      end
      if (!dif.coin_eject && dif.coin_value !== 5'd0) begin
        n_cmp++;
        n_err++;
        $display("FAIL idle_value: amt %0d cycle +%0d coin_value=%0d expected 0", amt, c,
                 dif.coin_value);
      end
      prev_e = dif.coin_eject;
      if (dif.done === 1'b1) begin
        cd = c;
        break;
      end
      dif.change_ready = (c == ovr_c);
      if (c == ovr_c) dif.change_amount = 7'($urandom_range(0, 127));
      dif.refill = refill_mid && (c == 3);
      if (refill_mid && c == 3) begin
        dif.refill_sel = 2'($urandom_range(0, 3));
        dif.refill_qty = IW'($urandom_range(1, MAXI));
      end
    end
    dif.change_ready = 1'b0;
    dif.refill       = 1'b0;

    exp_cd = 2 + PER * exp_q.size();
    n_cmp++;
    if (cd != exp_cd) begin
      n_err++;
      $display("FAIL done_time: amt %0d done at +%0d expected +%0d (-1 = timeout)", amt, cd, exp_cd);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL coin_count: amt %0d got %0d coins expected %0d", amt, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] != exp_q[i]) begin
        n_err++;
        $display("FAIL coin_value: amt %0d coin %0d got %0d expected %0d", amt, i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (int'(dif.shortfall) != m_short) begin
      n_err++;
      $display("FAIL shortfall: amt %0d got %0d expected %0d", amt, dif.shortfall, m_short);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (inv_of(k) != m_inv[k] || empty_of(k) != int'(m_inv[k] == 0)) begin
        n_err++;
        $display("FAIL inventory: amt %0d denom %0d got %0d/empty %0d expected %0d", amt, DV[k],
                 inv_of(k), empty_of(k), m_inv[k]);
      end
    end
`ifdef CHANGE_STATS_EN
    n_cmp++;
    if (int'(dif.total_paid) != m_paid || int'(dif.short_events) != m_sev) begin
      n_err++;
      $display("FAIL stats: paid %0d events %0d expected %0d %0d", dif.total_paid,
               dif.short_events, m_paid, m_sev);
    end
`endif
    tick();
    n_cmp++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin
      n_err++;
      $display("FAIL after_done: busy=%0b done=%0b expected 0 0", dif.busy, dif.done);
    end
  endtask

  task automatic do_refill(input int sel, input int qty);
    dif.refill     = 1'b1;
    dif.refill_sel = 2'(sel);
    dif.refill_qty = IW'(qty);
    tick();
    dif.refill = 1'b0;
    if (sel != 3) m_inv[sel] = (m_inv[sel] + qty > MAXI) ? MAXI : m_inv[sel] + qty;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (inv_of(k) != m_inv[k] || empty_of(k) != int'(m_inv[k] == 0)) begin
        n_err++;
        $display("FAIL refill: sel %0d qty %0d denom %0d got %0d expected %0d", sel, qty, DV[k],
                 inv_of(k), m_inv[k]);
      end
    end
  endtask

  task automatic test_reset();
    dif.change_amount = '0;
    dif.refill_sel    = '0;
    dif.refill_qty    = '0;
    reset = 1'b1;
    dif.change_ready = 1'b0;
    dif.refill       = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (dif.coin_eject !== 1'b0 || dif.coin_value !== 5'd0 || dif.busy !== 1'b0 ||
        dif.done !== 1'b0 || dif.shortfall !== 7'd0 || dif.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: eject %0b value %0d busy %0b done %0b short %0d ovr %0b expected all 0",
               dif.coin_eject, dif.coin_value, dif.busy, dif.done, dif.shortfall, dif.overrun);
    end
    n_cmp++;
    if (dif.inv_5 !== IW'(INIT) || dif.inv_10 !== IW'(INIT) || dif.inv_20 !== IW'(INIT) ||
        dif.empty_5 !== 1'b0 || dif.empty_10 !== 1'b0 || dif.empty_20 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_inventory: %0d/%0d/%0d expected %0d each", dif.inv_20, dif.inv_10,
               dif.inv_5, INIT);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic35();
    run_payout(35, 0, 1'b0, 1'b0);
    n_cmp++;
    if (dif.inv_20 !== 6'd7 || dif.inv_10 !== 6'd7 || dif.inv_5 !== 6'd7) begin
      n_err++;
      $display("FAIL basic35_inv: %0d/%0d/%0d expected 7/7/7", dif.inv_20, dif.inv_10, dif.inv_5);
    end
  endtask

  task automatic test_zero();
    run_payout(0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_fallback();
    do_reset();
    run_payout(120, 0, 1'b0, 1'b0);
    run_payout(40, 0, 1'b0, 1'b0);
    run_payout(40, 0, 1'b0, 1'b0);
    n_cmp++;
    if (dif.empty_20 !== 1'b1 || dif.inv_10 !== 6'd4) begin
      n_err++;
      $display("FAIL fallback: empty_20=%0b inv_10=%0d expected 1 and 4", dif.empty_20, dif.inv_10);
    end
  endtask

  task automatic test_shortfall();
    do_reset();
    run_payout(7, 0, 1'b0, 1'b0);
    n_cmp++;
    if (dif.shortfall !== 7'd2) begin
      n_err++;
      $display("FAIL short7: shortfall=%0d expected 2", dif.shortfall);
    end
    run_payout(120, 0, 1'b0, 1'b0);
    run_payout(120, 0, 1'b0, 1'b0);
    run_payout(30, 0, 1'b0, 1'b0);
    n_cmp++;
    if (dif.inv_5 !== 6'd1 || dif.inv_10 !== 6'd0 || dif.inv_20 !== 6'd0) begin
      n_err++;
      $display("FAIL short_setup: %0d/%0d/%0d expected 0/0/1", dif.inv_20, dif.inv_10, dif.inv_5);
    end
    run_payout(15, 0, 1'b0, 1'b0);
    n_cmp++;
    if (dif.shortfall !== 7'd10 || dif.empty_5 !== 1'b1) begin
      n_err++;
      $display("FAIL short15: shortfall=%0d empty_5=%0b expected 10 and 1", dif.shortfall, dif.empty_5);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    run_payout(35, 4, 1'b0, 1'b0);
    run_payout(50, 9, 1'b1, 1'b0);
  endtask

  task automatic test_refill_sat();
    do_reset();
    do_refill(2, 60);
    n_cmp++;
    if (dif.inv_20 !== 6'd63) begin
      n_err++;
      $display("FAIL refill_sat: inv_20=%0d expected 63", dif.inv_20);
    end
    do_refill(3, 5);
    do_refill(0, 1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    dif.change_amount = 7'd35;
    dif.change_ready  = 1'b1;
    tick();
    dif.change_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    n_cmp++;
    if (dif.coin_eject !== 1'b0 || dif.busy !== 1'b0 || dif.inv_20 !== IW'(INIT) ||
        dif.inv_10 !== IW'(INIT) || dif.inv_5 !== IW'(INIT) || dif.shortfall !== 7'd0) begin
      n_err++;
      $display("FAIL reset_mid: eject %0b busy %0b inv %0d/%0d/%0d short %0d expected 0 0 %0d each 0",
               dif.coin_eject, dif.busy, dif.inv_20, dif.inv_10, dif.inv_5, dif.shortfall, INIT);
    end
    tick();
  endtask

  task automatic test_priority();
    do_reset();
    run_payout(25, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) < 4)
        do_refill($urandom_range(0, 3), $urandom_range(0, MAXI));
      else
        run_payout($urandom_range(0, 127), ($urandom_range(0, 1) == 1) ? $urandom_range(2, 6) : 0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic35();
    test_zero();
    test_fallback();
    test_shortfall();
    test_overrun();
    test_refill_sat();
    test_reset_mid();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
